// File: rtl/pipe_wb_unit.sv
// Write-back stage: rf write-data select, 32x32 register file, HI/LO and retired counter.
// Optional macro WB_BYPASS_EN enables same-cycle write-through on rd1/rd2/hi/lo.
module pipe_wb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        Wvalid,
    input  logic [31:0] Walu,
    input  logic [31:0] Wa,
    input  logic [31:0] Wcounter,
    input  logic [31:0] Wcp0,
    input  logic [31:0] Wdm,
    input  logic [31:0] Wmuler_hi,
    input  logic [31:0] Wmuler_lo,
    input  logic [31:0] Wpc4,
    input  logic [31:0] Wq,
    input  logic [31:0] Wr,
    input  logic [2:0]  Wrfsource,
    input  logic [1:0]  Whisource,
    input  logic [1:0]  Wlosource,
    input  logic [4:0]  Wrn,
    input  logic        Ww_rf,
    input  logic        Ww_hi,
    input  logic        Ww_lo,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] wb_data,
    output logic [31:0] retired
);

    logic [31:0] rf_q [0:31];
    logic [31:0] hi_q, lo_q, retired_q;
    logic [31:0] wb_data_d, hi_d, lo_d, retired_d;
    logic        we_rf, we_hi, we_lo;

    // Enables fold in rst so nothing commits on a reset edge.
    assign we_rf = Wvalid & Ww_rf & (Wrn != 5'd0) & rst;
    assign we_hi = Wvalid & Ww_hi & rst;
    assign we_lo = Wvalid & Ww_lo & rst;

    always_comb begin
        wb_data_d = Walu;
        case (Wrfsource)
            3'd0: wb_data_d = Walu;
            3'd1: wb_data_d = Wdm;
            3'd2: wb_data_d = Wpc4;
            3'd3: wb_data_d = hi_q;
            3'd4: wb_data_d = lo_q;
            3'd5: wb_data_d = Wcp0;
            3'd6: wb_data_d = Wcounter;
            default: wb_data_d = Wmuler_lo;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        case (Whisource)
            2'd0: hi_d = Wa;
            2'd1: hi_d = Wmuler_hi;
            2'd2: hi_d = Wr;
            default: hi_d = hi_q;
        endcase
    end

    always_comb begin
        lo_d = lo_q;
        case (Wlosource)
            2'd0: lo_d = Wa;
            2'd1: lo_d = Wmuler_lo;
            2'd2: lo_d = Wq;
            default: lo_d = lo_q;
        endcase
    end

    assign retired_d = retired_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            if (we_rf) begin
                rf_q[Wrn] <= wb_data_d;
            end
            if (we_hi) begin
                hi_q <= hi_d;
            end
            if (we_lo) begin
                lo_q <= lo_d;
            end
            if (Wvalid) begin
                retired_q <= retired_d;
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd1 = rf_q[ra1];
        rd2 = rf_q[ra2];
        if (we_rf && (Wrn == ra1)) rd1 = wb_data_d;
        if (we_rf && (Wrn == ra2)) rd2 = wb_data_d;
        if (ra1 == 5'd0) rd1 = 32'd0;
        if (ra2 == 5'd0) rd2 = 32'd0;
    end
    assign hi = we_hi ? hi_d : hi_q;
    assign lo = we_lo ? lo_d : lo_q;
`else
    always_comb begin
        rd1 = rf_q[ra1];
        rd2 = rf_q[ra2];
        if (ra1 == 5'd0) rd1 = 32'd0;
        if (ra2 == 5'd0) rd2 = 32'd0;
    end
    assign hi = hi_q;
    assign lo = lo_q;
`endif

    assign wb_data = wb_data_d;
    assign retired = retired_q;

endmodule

// File: tb/tb_pipe_wb_unit.sv
// Self-checking bench for pipe_wb_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Wvalid;
    logic [31:0] Walu, Wa, Wcounter, Wcp0, Wdm, Wmuler_hi, Wmuler_lo, Wpc4, Wq, Wr;
    logic [2:0]  Wrfsource;
    logic [1:0]  Whisource, Wlosource;
    logic [4:0]  Wrn, ra1, ra2;
    logic        Ww_rf, Ww_hi, Ww_lo;
    logic [31:0] rd1, rd2, hi, lo, wb_data, retired;

    always #5 clk = ~clk;

    pipe_wb_unit dut (
        .clk(clk), .rst(rst), .Wvalid(Wvalid),
        .Walu(Walu), .Wa(Wa), .Wcounter(Wcounter), .Wcp0(Wcp0), .Wdm(Wdm),
        .Wmuler_hi(Wmuler_hi), .Wmuler_lo(Wmuler_lo), .Wpc4(Wpc4), .Wq(Wq), .Wr(Wr),
        .Wrfsource(Wrfsource), .Whisource(Whisource), .Wlosource(Wlosource),
        .Wrn(Wrn), .Ww_rf(Ww_rf), .Ww_hi(Ww_hi), .Ww_lo(Ww_lo),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .hi(hi), .lo(lo),
        .wb_data(wb_data), .retired(retired)
    );

    // Architectural state as the instruction set sees it.
    logic [31:0] m_rf [32];
    logic [31:0] m_hi, m_lo, m_ret;
    bit          model_ok = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        logic [31:0] srcs [8];
        srcs[0] = Walu; srcs[1] = Wdm; srcs[2] = Wpc4; srcs[3] = m_hi;
        srcs[4] = m_lo; srcs[5] = Wcp0; srcs[6] = Wcounter; srcs[7] = Wmuler_lo;
        return srcs[Wrfsource];
    endfunction

    function automatic logic [31:0] exp_hi_next();
        logic [31:0] srcs [4];
        srcs[0] = Wa; srcs[1] = Wmuler_hi; srcs[2] = Wr; srcs[3] = m_hi;
        return srcs[Whisource];
    endfunction

    function automatic logic [31:0] exp_lo_next();
        logic [31:0] srcs [4];
        srcs[0] = Wa; srcs[1] = Wmuler_lo; srcs[2] = Wq; srcs[3] = m_lo;
        return srcs[Wlosource];
    endfunction

    function automatic bit rf_commits();
        return rst && Wvalid && Ww_rf && (Wrn != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (rf_commits() && Wrn == a) return exp_wb();
`endif
        return m_rf[a];
    endfunction

    task automatic compare_all();
        logic [31:0] eh, el;
        eh = m_hi;
        el = m_lo;
`ifdef WB_BYPASS_EN
        if (rst && Wvalid && Ww_hi) eh = exp_hi_next();
        if (rst && Wvalid && Ww_lo) el = exp_lo_next();
`endif
        chk("wb_data", wb_data, exp_wb());
        chk("rd1", rd1, exp_rd(ra1));
        chk("rd2", rd2, exp_rd(ra2));
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("retired", retired, m_ret);
    endtask

    // One clock: settle, check, advance model and DUT, return at the next falling edge.
    task automatic tick();
        logic [31:0] nwb, nhi, nlo;
        bit wrf, whi, wlo, clr;
        #1;
        if (model_ok) compare_all();
        nwb = exp_wb(); nhi = exp_hi_next(); nlo = exp_lo_next();
        wrf = rf_commits();
        whi = rst && Wvalid && Ww_hi;
        wlo = rst && Wvalid && Ww_lo;
        clr = !rst;
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_hi = 32'd0; m_lo = 32'd0; m_ret = 32'd0;
            model_ok = 1'b1;
        end else begin
            if (wrf) m_rf[Wrn] = nwb;
            if (whi) m_hi = nhi;
            if (wlo) m_lo = nlo;
            if (Wvalid) m_ret = m_ret + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic bubble();
        rst = 1'b1; Wvalid = 1'b0;
        Walu = 0; Wa = 0; Wcounter = 0; Wcp0 = 0; Wdm = 0; Wmuler_hi = 0; Wmuler_lo = 0;
        Wpc4 = 0; Wq = 0; Wr = 0; Wrfsource = 0; Whisource = 2'd3; Wlosource = 2'd3;
        Wrn = 0; Ww_rf = 0; Ww_hi = 0; Ww_lo = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic randomize_inputs();
        rst       = ($urandom_range(0, 39) != 0);
        Wvalid    = ($urandom_range(0, 3) != 0);
        Walu = $urandom; Wa = $urandom; Wcounter = $urandom; Wcp0 = $urandom; Wdm = $urandom;
        Wmuler_hi = $urandom; Wmuler_lo = $urandom; Wpc4 = $urandom; Wq = $urandom; Wr = $urandom;
        Wrfsource = 3'($urandom_range(0, 7));
        Whisource = 2'($urandom_range(0, 3));
        Wlosource = 2'($urandom_range(0, 3));
        Wrn       = 5'($urandom_range(0, 7));
        Ww_rf = 1'($urandom_range(0, 1)); Ww_hi = 1'($urandom_range(0, 1)); Ww_lo = 1'($urandom_range(0, 1));
        ra1 = 5'($urandom_range(0, 7));
        ra2 = 5'($urandom_range(0, 7));
    endtask

    initial begin
        bubble();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Fill r1..r31, HI, LO with all-ones, then reset with a write in flight.
        for (int i = 1; i < 32; i++) begin
            bubble();
            Wvalid = 1; Ww_rf = 1; Wrn = 5'(i); Walu = 32'hFFFFFFFF;
            Ww_hi = 1; Ww_lo = 1; Whisource = 0; Wlosource = 0; Wa = 32'hFFFFFFFF;
            tick();
        end
        bubble(); ra1 = 5'd17; #1;
        chk("fill_r17", rd1, 32'hFFFFFFFF);
        rst = 0; Wvalid = 1; Ww_rf = 1; Wrn = 5'd9; Walu = 32'h1111_2222;
        tick();
        bubble(); ra1 = 5'd31; ra2 = 5'd9; #1;
        chk("reset_r31", rd1, 32'd0);
        chk("reset_r9", rd2, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_retired", retired, 32'd0);

        // Write/read r5.
        bubble(); Wvalid = 1; Ww_rf = 1; Wrn = 5'd5; Wrfsource = 3'd1; Wdm = 32'hDEADBEEF; ra1 = 5'd5; #1;
`ifdef WB_BYPASS_EN
        chk("r5_same_cycle", rd1, 32'hDEADBEEF);
`else
        chk("r5_same_cycle", rd1, 32'd0);
`endif
        tick();
        bubble(); ra1 = 5'd5; #1;
        chk("r5_next_cycle", rd1, 32'hDEADBEEF);

        // r0 is never writable, bypass included.
        bubble(); Wvalid = 1; Ww_rf = 1; Wrn = 5'd0; Walu = 32'h1234; ra1 = 5'd0; #1;
        chk("r0_same_cycle", rd1, 32'd0);
        tick();
        bubble(); #1;
        chk("r0_after", rd1, 32'd0);

        // HI/LO from multiplier, then mfhi into r3.
        bubble(); Wvalid = 1; Ww_hi = 1; Ww_lo = 1; Whisource = 2'd1; Wlosource = 2'd1;
        Wmuler_hi = 32'h1; Wmuler_lo = 32'h2;
        tick();
        bubble(); #1;
        chk("hi_mul", hi, 32'h1);
        chk("lo_mul", lo, 32'h2);
        Wvalid = 1; Ww_rf = 1; Wrn = 5'd3; Wrfsource = 3'd3; #1;
        chk("mfhi_wb", wb_data, 32'h1);
        tick();
        bubble(); ra1 = 5'd3; #1;
        chk("r3_mfhi", rd1, 32'h1);

        // mfhi and HI write in one instruction: rf gets the old HI.
        bubble(); Wvalid = 1; Ww_rf = 1; Wrn = 5'd4; Wrfsource = 3'd3; Ww_hi = 1; Whisource = 2'd0; Wa = 32'h77;
        Wrfsource = 3'd3; #1;
        chk("mfhi_old_wb", wb_data, 32'h1);
        tick();
        bubble(); ra1 = 5'd4; #1;
        chk("r4_old_hi", rd1, 32'h1);
        chk("hi_new", hi, 32'h77);

        // Bubble with enables set changes nothing.
        bubble(); Ww_rf = 1; Wrn = 5'd7; Walu = 32'h55; Ww_hi = 1; Whisource = 2'd0; Wa = 32'h99;
        tick();
        bubble(); ra1 = 5'd7; #1;
        chk("bubble_r7", rd1, 32'd0);
        chk("bubble_hi", hi, 32'h77);
        chk("bubble_retired", retired, 32'd5);

        // Reset arriving with a valid instruction in W.
        bubble(); rst = 0; Wvalid = 1; Ww_rf = 1; Wrn = 5'd6; Walu = 32'hABCD;
        tick();
        bubble(); ra1 = 5'd6; ra2 = 5'd5; #1;
        chk("midreset_r6", rd1, 32'd0);
        chk("midreset_r5", rd2, 32'd0);
        chk("midreset_retired", retired, 32'd0);

        // Counter wrap from a preloaded value.
        bubble();
        force dut.retired_q = 32'hFFFFFFFE;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFFFFFE;
        Wvalid = 1;
        tick();
        bubble(); #1;
        chk("retired_max", retired, 32'hFFFFFFFF);
        Wvalid = 1;
        tick();
        bubble(); #1;
        chk("retired_wrap", retired, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            tick();
        end
        bubble();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
